// File: rtl/wb_stage_buffered.sv
// Writeback stage: selects link/ALU/load data, waits on variable-latency loads with a timeout,
// and issues registered regfile, pc_sel and CSR write pulses.
module wb_stage_buffered #(
    parameter int          XLEN       = 32,
    parameter int          PC_INC     = 4,
    parameter int          LD_TIMEOUT = 15,
    parameter logic [11:0] CSR_ADDR   = 12'h51E
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [31:0]     in_inst,
    input  logic            in_jump,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pc_sel,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wdata,
    output logic            ld_err
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam int         CW         = $clog2(LD_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_LD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      ld_funct3;
    logic [4:0]      ld_rd;
    logic [1:0]      ld_off;
    logic            ld_jump;
    logic            accept, accept_load;
    logic            rf_we_nxt, pc_sel_nxt, csr_we_nxt, ld_err_nxt;
    logic [4:0]      rf_waddr_nxt;
    logic [XLEN-1:0] rf_wdata_nxt, csr_wdata_nxt;
    logic            unused_rs1;

    assign unused_rs1  = ^in_inst[19:15];
    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign accept_load = accept && (in_inst[6:0] == OPC_LOAD);

    function automatic logic writes_rd(input logic [31:0] inst);
        logic w;
        w = 1'b0;
        case (inst[6:0])
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC,
            OPC_OP, OPC_OPIMM, OPC_LOAD: w = 1'b1;
            OPC_SYSTEM:                  w = (inst[14:12] != 3'b000);
            default:                     w = 1'b0;
        endcase
        return w && (inst[11:7] != 5'd0);
    endfunction

    function automatic logic is_csr_write(input logic [31:0] inst);
        return (inst[6:0] == OPC_SYSTEM) &&
               ((inst[14:12] == 3'b001) || (inst[14:12] == 3'b101)) &&
               (inst[31:20] == CSR_ADDR);
    endfunction

    // Sub-word loads pick a byte/half from the aligned word using the address offset
    function automatic logic [XLEN-1:0] extract_load(input logic [2:0] funct3,
                                                     input logic [1:0] off,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Data outputs are zero outside their strobe cycle so a stale value is never visible
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rf_we_nxt     = 1'b0;
        rf_waddr_nxt  = 5'd0;
        rf_wdata_nxt  = '0;
        pc_sel_nxt    = 1'b0;
        csr_we_nxt    = 1'b0;
        csr_wdata_nxt = '0;
        ld_err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept_load) begin
                    state_nxt = WAIT_LD;
                    cnt_nxt   = '0;
                end else if (accept) begin
                    rf_we_nxt  = writes_rd(in_inst);
                    pc_sel_nxt = in_jump;
                    csr_we_nxt = is_csr_write(in_inst);
                    if (rf_we_nxt) begin
                        rf_waddr_nxt = in_inst[11:7];
                        rf_wdata_nxt = (in_inst[6:0] == OPC_JAL || in_inst[6:0] == OPC_JALR) ?
                                       in_pc + XLEN'(PC_INC) : in_alu;
                    end
                    if (csr_we_nxt) begin
                        csr_wdata_nxt = in_alu;
                    end
                end
            end
            WAIT_LD: begin
                if (mem_rvalid) begin
                    state_nxt  = IDLE;
                    rf_we_nxt  = (ld_rd != 5'd0);
                    pc_sel_nxt = ld_jump;
                    if (rf_we_nxt) begin
                        rf_waddr_nxt = ld_rd;
                        rf_wdata_nxt = extract_load(ld_funct3, ld_off, mem_rdata);
                    end
                end else if (cnt == CW'(LD_TIMEOUT)) begin
                    state_nxt  = IDLE;
                    ld_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_funct3 <= 3'd0;
            ld_rd     <= 5'd0;
            ld_off    <= 2'd0;
            ld_jump   <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= '0;
            pc_sel    <= 1'b0;
            csr_we    <= 1'b0;
            csr_wdata <= '0;
            ld_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rf_we     <= rf_we_nxt;
            rf_waddr  <= rf_waddr_nxt;
            rf_wdata  <= rf_wdata_nxt;
            pc_sel    <= pc_sel_nxt;
            csr_we    <= csr_we_nxt;
            csr_wdata <= csr_wdata_nxt;
            ld_err    <= ld_err_nxt;
            if (accept_load) begin
                ld_funct3 <= in_inst[14:12];
                ld_rd     <= in_inst[11:7];
                ld_off    <= in_alu[1:0];
                ld_jump   <= in_jump;
            end
        end
    end

endmodule
